// File: rtl/tpg_multi.sv
// Traffic pattern generator for a NoC node: emits packets of PKT_LEN flits to a fixed,
// round-robin or LFSR-random destination. Define TPG_LOG_EN to log every handshake.
`timescale 1ns/1ps
module tpg_multi #(
  parameter int                        WIDTH        = 32,
  parameter int                        N            = 16,
  parameter int                        N_ADDR_WIDTH = $clog2(N),
  parameter logic [7:0]                ID           = 8'd0,
  parameter logic [N_ADDR_WIDTH-1:0]   NODE         = N_ADDR_WIDTH'(15),
  parameter logic [N_ADDR_WIDTH-1:0]   DEST         = N_ADDR_WIDTH'(15),
  parameter int                        MODE         = 0,
  parameter int                        PKT_LEN      = 1,
  parameter int                        GAP          = 0,
  parameter int                        NUM_PKTS     = 0,
  parameter logic [15:0]               SEED         = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic [WIDTH-1:0]        data_out,
  output logic [N_ADDR_WIDTH-1:0] dest_out,
  output logic                    valid_out,
  output logic                    tail_out,
  input  logic                    ready_in,
  output logic                    done_out
);

  localparam int              AW        = N_ADDR_WIDTH;
  localparam int              SW        = WIDTH - 2*AW - 8;
  localparam logic [AW-1:0]   LAST_NODE = AW'(N - 1);
  localparam logic [AW-1:0]   NODE_NEXT = (NODE == LAST_NODE) ? {AW{1'b0}} : NODE + AW'(1);
  localparam logic [AW-1:0]   RST_DEST  = (MODE == 0) ? DEST : {AW{1'b0}};
  localparam logic [31:0]     PKT_LAST  = 32'(PKT_LEN - 1);
  localparam logic [31:0]     NP        = 32'(NUM_PKTS);
  localparam logic [31:0]     GAP_LAST  = (GAP > 0) ? 32'(GAP - 1) : 32'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   dest_q, dest_d;
  logic [SW-1:0]   seq_q, seq_d;
  logic [31:0]     flit_q, flit_d;
  logic [31:0]     pkt_q, pkt_d;
  logic [31:0]     gap_q, gap_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [AW-1:0]   rr_q, rr_d;
  logic            valid_q, valid_d;
  logic            tail_q, tail_d;
  logic            done_q, done_d;

  logic            hs_s;
  logic [AW-1:0]   rr_nxt_s;
  logic [15:0]     lfsr_nxt_s;
  logic [AW-1:0]   lfsr_dest_s;
  logic [AW-1:0]   new_dest_s;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == LAST_NODE) ? {AW{1'b0}} : a + AW'(1);
  endfunction

  assign hs_s = valid_q & ready_in;

  // Destination candidate for the next packet start.
  always_comb begin
    rr_nxt_s = addr_inc(rr_q);
    if (rr_nxt_s == NODE) begin
      rr_nxt_s = addr_inc(rr_nxt_s);
    end else begin
      rr_nxt_s = rr_nxt_s;
    end
    lfsr_nxt_s  = lfsr_step(lfsr_q);
    lfsr_dest_s = lfsr_nxt_s[AW-1:0];
    if (lfsr_dest_s == NODE) begin
      lfsr_dest_s = NODE_NEXT;
    end else begin
      lfsr_dest_s = lfsr_dest_s;
    end
    if (MODE == 1) begin
      new_dest_s = rr_nxt_s;
    end else if (MODE == 2) begin
      new_dest_s = lfsr_dest_s;
    end else begin
      new_dest_s = DEST;
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    seq_d   = seq_q;
    flit_d  = flit_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    lfsr_d  = lfsr_q;
    rr_d    = rr_q;
    valid_d = valid_q;
    tail_d  = tail_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          tail_d  = (PKT_LAST == 32'd0);
          flit_d  = 32'd0;
          seq_d   = seq_q + SW'(1);
          dest_d  = new_dest_s;
          if (MODE == 1) begin
            rr_d = rr_nxt_s;
          end else begin
            rr_d = rr_q;
          end
          if (MODE == 2) begin
            lfsr_d = lfsr_nxt_s;
          end else begin
            lfsr_d = lfsr_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (hs_s && tail_q) begin
          valid_d = 1'b0;
          tail_d  = 1'b0;
          flit_d  = 32'd0;
          if ((NUM_PKTS != 0) && (pkt_q != NP)) begin
            pkt_d = pkt_q + 32'd1;
          end else begin
            pkt_d = pkt_q;
          end
          if ((NUM_PKTS != 0) && (pkt_q + 32'd1 >= NP)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LAST;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hs_s) begin
          flit_d = flit_q + 32'd1;
          seq_d  = seq_q + SW'(1);
          tail_d = ((flit_q + 32'd1) == PKT_LAST);
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_q == 32'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      ST_DONE: begin
        valid_d = 1'b0;
        tail_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        tail_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dest_q  <= RST_DEST;
      seq_q   <= {SW{1'b0}};
      flit_q  <= 32'd0;
      pkt_q   <= 32'd0;
      gap_q   <= 32'd0;
      lfsr_q  <= SEED;
      rr_q    <= NODE;
      valid_q <= 1'b0;
      tail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      seq_q   <= seq_d;
      flit_q  <= flit_d;
      pkt_q   <= pkt_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      tail_q  <= tail_d;
      done_q  <= done_d;
    end
  end

  assign data_out  = {NODE, dest_q, ID, seq_q};
  assign dest_out  = dest_q;
  assign valid_out = valid_q;
  assign tail_out  = tail_q;
  assign done_out  = done_q;

`ifdef TPG_LOG_EN
  // Record each accepted flit.
  always @(posedge clk) begin
    if (!rst && hs_s) begin
      $display("SEND; time=%0t; from=%0d; to=%0d; id=%0d; seq=%0d; tail=%0d;",
               $time, NODE, dest_q, ID, seq_q, tail_q);
    end
  end
`endif

endmodule

// File: tb/tb_tpg_multi.sv
// Directed bench for tpg_multi: four instances cover fixed, multi-flit/gap/reset, round-robin and LFSR modes.
`timescale 1ns/1ps
module tb_tpg_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic rst0, en0, rdy0, rst1, en1, rdy1, rst2, en2, rdy2, rst3, en3, rdy3;
  logic [31:0] data0, data1, data2, data3;
  logic [3:0]  dest0, dest1, dest3;
  logic [1:0]  dest2;
  logic v0, v1, v2, v3, t0, t1, t2, t3, d0, d1, d2, d3;

  tpg_multi #(.ID(8'hA5), .DEST(4'd5)) u0 (
    .clk(clk), .rst(rst0), .enable(en0), .data_out(data0), .dest_out(dest0),
    .valid_out(v0), .tail_out(t0), .ready_in(rdy0), .done_out(d0));

  tpg_multi #(.ID(8'h11), .NODE(4'd2), .DEST(4'd3), .PKT_LEN(4), .GAP(3)) u1 (
    .clk(clk), .rst(rst1), .enable(en1), .data_out(data1), .dest_out(dest1),
    .valid_out(v1), .tail_out(t1), .ready_in(rdy1), .done_out(d1));

  tpg_multi #(.N(4), .ID(8'h22), .NODE(2'd1), .DEST(2'd3), .MODE(1), .NUM_PKTS(5)) u2 (
    .clk(clk), .rst(rst2), .enable(en2), .data_out(data2), .dest_out(dest2),
    .valid_out(v2), .tail_out(t2), .ready_in(rdy2), .done_out(d2));

  tpg_multi #(.ID(8'h33), .MODE(2)) u3 (
    .clk(clk), .rst(rst3), .enable(en3), .data_out(data3), .dest_out(dest3),
    .valid_out(v3), .tail_out(t3), .ready_in(rdy3), .done_out(d3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] f16(input logic [3:0] node, input logic [3:0] dst,
                                      input logic [7:0] id, input logic [15:0] seq);
    return {node, dst, id, seq};
  endfunction

  function automatic logic [31:0] f20(input logic [1:0] node, input logic [1:0] dst,
                                      input logic [7:0] id, input logic [19:0] seq);
    return {node, dst, id, seq};
  endfunction

  logic [1:0] rr_exp [5];
  logic [3:0] lf_exp [5];

  initial begin
    rr_exp = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    lf_exp = '{4'h0, 4'h8, 4'hC, 4'hE, 4'h7};
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;
    tick(); tick();

    // reset state
    check("rst_valid0", {63'd0, v0}, 64'd0);
    check("rst_tail0",  {63'd0, t0}, 64'd0);
    check("rst_done0",  {63'd0, d0}, 64'd0);
    check("rst_data0",  {32'd0, data0}, {32'd0, f16(4'hF, 4'd5, 8'hA5, 16'd0)});
    check("rst_dest1",  {60'd0, dest1}, 64'd3);
    check("rst_dest2",  {62'd0, dest2}, 64'd0);
    check("rst_dest3",  {60'd0, dest3}, 64'd0);
    check("rst_data2",  {32'd0, data2}, {32'd0, f20(2'd1, 2'd0, 8'h22, 20'd0)});

    // fixed destination, single-flit packets every other cycle
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    en0 = 1'b1; rdy0 = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      check("m0_valid", {63'd0, v0}, 64'd1);
      check("m0_data",  {32'd0, data0}, {32'd0, f16(4'hF, 4'd5, 8'hA5, 16'(k))});
      check("m0_tail",  {63'd0, t0}, 64'd1);
      check("m0_dest",  {60'd0, dest0}, 64'd5);
      tick();
      check("m0_idle",  {63'd0, v0}, 64'd0);
      tick();
    end

    // four-flit packet, stall on flit 2, enable dropped mid-packet
    en1 = 1'b1; rdy1 = 1'b1;
    tick();
    check("p4_f1_data", {32'd0, data1}, {32'd0, f16(4'h2, 4'd3, 8'h11, 16'd1)});
    check("p4_f1_tail", {63'd0, t1}, 64'd0);
    en1 = 1'b0;
    tick();
    rdy1 = 1'b0;
    check("p4_f2_data", {32'd0, data1}, {32'd0, f16(4'h2, 4'd3, 8'h11, 16'd2)});
    for (int k = 0; k < 3; k++) begin
      tick();
      check("p4_hold_valid", {63'd0, v1}, 64'd1);
      check("p4_hold_data",  {32'd0, data1}, {32'd0, f16(4'h2, 4'd3, 8'h11, 16'd2)});
      check("p4_hold_tail",  {63'd0, t1}, 64'd0);
    end
    rdy1 = 1'b1;
    tick();
    check("p4_f3_data", {32'd0, data1}, {32'd0, f16(4'h2, 4'd3, 8'h11, 16'd3)});
    check("p4_f3_tail", {63'd0, t1}, 64'd0);
    tick();
    check("p4_f4_data", {32'd0, data1}, {32'd0, f16(4'h2, 4'd3, 8'h11, 16'd4)});
    check("p4_f4_tail", {63'd0, t1}, 64'd1);
    en1 = 1'b1;

    // three gap cycles then one idle cycle before the next packet
    for (int k = 0; k < 4; k++) begin
      tick();
      check("gap_valid", {63'd0, v1}, 64'd0);
      check("gap_tail",  {63'd0, t1}, 64'd0);
    end
    tick();
    check("gap_next_valid", {63'd0, v1}, 64'd1);
    check("gap_next_data",  {32'd0, data1}, {32'd0, f16(4'h2, 4'd3, 8'h11, 16'd5)});

    // reset on flit 2 drops the packet; next packet restarts at seq 1
    tick();
    check("rp_f2_data", {32'd0, data1}, {32'd0, f16(4'h2, 4'd3, 8'h11, 16'd6)});
    rst1 = 1'b1;
    tick();
    check("rp_valid", {63'd0, v1}, 64'd0);
    check("rp_tail",  {63'd0, t1}, 64'd0);
    check("rp_data",  {32'd0, data1}, {32'd0, f16(4'h2, 4'd3, 8'h11, 16'd0)});
    rst1 = 1'b0;
    tick();
    check("rp_restart_valid", {63'd0, v1}, 64'd1);
    check("rp_restart_data",  {32'd0, data1}, {32'd0, f16(4'h2, 4'd3, 8'h11, 16'd1)});
    check("rp_restart_tail",  {63'd0, t1}, 64'd0);
    en1 = 1'b0;

    // round-robin with packet limit, and LFSR destinations
    en2 = 1'b1; rdy2 = 1'b1; en3 = 1'b1; rdy3 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("rr_valid", {63'd0, v2}, 64'd1);
      check("rr_dest",  {62'd0, dest2}, {62'd0, rr_exp[i]});
      check("rr_data",  {32'd0, data2}, {32'd0, f20(2'd1, rr_exp[i], 8'h22, 20'(i + 1))});
      check("lf_valid", {63'd0, v3}, 64'd1);
      check("lf_dest",  {60'd0, dest3}, {60'd0, lf_exp[i]});
      check("lf_not_node", {63'd0, (dest3 == 4'hF)}, 64'd0);
      check("lf_data",  {32'd0, data3}, {32'd0, f16(4'hF, lf_exp[i], 8'h33, 16'(i + 1))});
      tick();
      check("rr_gap_valid", {63'd0, v2}, 64'd0);
      check("rr_done", {63'd0, d2}, {63'd0, (i == 4)});
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      check("done_hold", {63'd0, d2}, 64'd1);
      check("done_valid", {63'd0, v2}, 64'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
